pwm_multi_ctrl: RTL and testbench

//   Multi-channel PWM generator with debounced up/down duty-cycle buttons.

---
 rtl/pwm_multi_ctrl_if.sv | 27 ++
 rtl/pwm_multi_ctrl.sv | 142 ++++++++++++++
 tb/tb_pwm_multi_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_ctrl_if.sv
// Board-side bundle of the PWM controller: config pins and buttons in,
// PWM outputs, period sync and duty readback out.
interface pwm_multi_ctrl_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
);
  logic             en;
  logic             btn_inc;
  logic             btn_dec;
  logic [SEL_W-1:0] ch_sel;
  logic             mode_center;
  logic [CNT_W-1:0] period;
  logic [NCH-1:0]   pwm_out;
  logic             sync_pulse;
  logic [CNT_W-1:0] duty_rd;

  modport master (
    output en, btn_inc, btn_dec, ch_sel, mode_center, period,
    input  pwm_out, sync_pulse, duty_rd
  );

  modport slave (
    input  en, btn_inc, btn_dec, ch_sel, mode_center, period,
    output pwm_out, sync_pulse, duty_rd
  );
endinterface

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with debounced duty buttons, edge/center modes
// and period-boundary shadowing of period, mode and duty.
module pwm_multi_ctrl #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int STEP      = 1,
  parameter int DEB_DIV   = 4,
  parameter int DUTY_INIT = 0
) (
  input logic             clk,
  input logic             rst,
  pwm_multi_ctrl_if.slave bus
);
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TICK_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_DIV - 1);
  localparam logic [SEL_W:0]    NCH_V     = (SEL_W + 1)'(NCH);
  localparam logic [CNT_W-1:0]  DUTY_MAX  = '1;
  localparam logic [CNT_W-1:0]  STEP_V    = CNT_W'(STEP);
  localparam logic [CNT_W-1:0]  DUTY_RST  = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO       = CNT_W'(2);

  // Button pipeline bits: [0],[1] synchroniser, [2],[3] tick-enabled stages.
  function automatic logic [3:0] deb_next(input logic [3:0] sh, input logic raw,
                                          input logic t);
    return t ? {sh[2], sh[1], sh[0], raw} : {sh[3], sh[2], sh[0], raw};
  endfunction

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [3:0]        inc_sh_q, inc_sh_d, dec_sh_q, dec_sh_d;
  logic              inc_press, dec_press, sel_ok;
  logic [CNT_W-1:0]  duty_q [NCH];
  logic [CNT_W-1:0]  duty_d [NCH];
  logic [CNT_W-1:0]  duty_rd_c;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_down_q, dir_down_d;
  logic [CNT_W-1:0]  shadow_period_q, shadow_period_d;
  logic              shadow_mode_q, shadow_mode_d;
  logic [CNT_W-1:0]  shadow_duty_q [NCH];
  logic [CNT_W-1:0]  shadow_duty_d [NCH];
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic              sync_q, sync_d;
  logic              boundary, run;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    inc_sh_d   = deb_next(inc_sh_q, bus.btn_inc, tick);
    dec_sh_d   = deb_next(dec_sh_q, bus.btn_dec, tick);
    inc_press  = inc_sh_q[2] & ~inc_sh_q[3] & tick;
    dec_press  = dec_sh_q[2] & ~dec_sh_q[3] & tick;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    duty_d    = duty_q;
    duty_rd_c = '0;
    sel_ok    = ({1'b0, bus.ch_sel} < NCH_V);
    for (int i = 0; i < NCH; i++) begin
      if (sel_ok && bus.ch_sel == SEL_W'(i)) begin
        duty_rd_c = duty_q[i];
        if (inc_press && !dec_press)
          duty_d[i] = (duty_q[i] > DUTY_MAX - STEP_V) ? DUTY_MAX : duty_q[i] + STEP_V;
        else if (dec_press && !inc_press)
          duty_d[i] = (duty_q[i] < STEP_V) ? '0 : duty_q[i] - STEP_V;
      end
    end
  end

  // At a boundary the incoming settings take effect in that same cycle, so the
  // shadow next-state values double as the effective values for this cycle.
  always_comb begin
    boundary        = bus.en && (cnt_q == '0) && !dir_down_q;
    shadow_period_d = boundary ? bus.period      : shadow_period_q;
    shadow_mode_d   = boundary ? bus.mode_center : shadow_mode_q;
    for (int i = 0; i < NCH; i++)
      shadow_duty_d[i] = boundary ? duty_q[i] : shadow_duty_q[i];
    run        = bus.en && (shadow_period_d >= TWO);
    cnt_d      = '0;
    dir_down_d = 1'b0;
    if (run) begin
      if (!shadow_mode_d) begin
        cnt_d = (cnt_q >= shadow_period_d - ONE) ? '0 : cnt_q + ONE;
      end else if (!dir_down_q) begin
        if (cnt_q >= shadow_period_d - ONE) begin
          cnt_d      = cnt_q;
          dir_down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (cnt_q != '0) begin
        cnt_d      = cnt_q - ONE;
        dir_down_d = 1'b1;
      end
    end
    // Center mode compares the mirrored count so the high window straddles the peak.
    for (int i = 0; i < NCH; i++)
      pwm_d[i] = run && (shadow_mode_d ? ((shadow_period_d - ONE - cnt_q) < shadow_duty_d[i])
                                       : (cnt_q < shadow_duty_d[i]));
    sync_d = boundary && run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: duty and shadow arrays are a handful of flops, not a RAM, so resetting them is cheap and required.
      tick_cnt_q      <= '0;
      inc_sh_q        <= '0;
      dec_sh_q        <= '0;
      cnt_q           <= '0;
      dir_down_q      <= 1'b0;
      shadow_period_q <= '0;
      shadow_mode_q   <= 1'b0;
      pwm_q           <= '0;
      sync_q          <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_q[i]        <= DUTY_RST;
        shadow_duty_q[i] <= '0;
      end
    end else begin
      tick_cnt_q      <= tick_cnt_d;
      inc_sh_q        <= inc_sh_d;
      dec_sh_q        <= dec_sh_d;
      cnt_q           <= cnt_d;
      dir_down_q      <= dir_down_d;
      shadow_period_q <= shadow_period_d;
      shadow_mode_q   <= shadow_mode_d;
      pwm_q           <= pwm_d;
      sync_q          <= sync_d;
      for (int i = 0; i < NCH; i++) begin
        duty_q[i]        <= duty_d[i];
        shadow_duty_q[i] <= shadow_duty_d[i];
      end
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.sync_pulse = sync_q;
  assign bus.duty_rd    = duty_rd_c;
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: a table of PWM window measurements plus
// hand-written sequences for debounce, saturation, mid-period change and reset.
module tb_pwm_multi_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pwm_multi_ctrl_if #(.NCH(4), .CNT_W(8)) bus ();

  pwm_multi_ctrl #(
    .NCH(4), .CNT_W(8), .STEP(1), .DEB_DIV(4), .DUTY_INIT(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit mode;
    int period;
    int duty;
    int exp_high;
    int exp_len;
    int exp_first;
    int exp_runs;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold a button level long enough for the debouncer to accept it, then release.
  task automatic press(input bit inc, input bit dec);
    bus.btn_inc = inc;
    bus.btn_dec = dec;
    repeat (16) @(posedge clk);
    #1;
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input int ch, input int target);
    bus.ch_sel = 2'(ch);
    #1;
    for (int n = 0; n < 300 && int'(bus.duty_rd) != target; n++)
      press(int'(bus.duty_rd) < target, int'(bus.duty_rd) > target);
    check($sformatf("set_duty ch%0d", ch), int'(bus.duty_rd), target);
  endtask

  // Wait for a sync pulse, then characterise pwm_out[ch] up to the next one.
  task automatic measure(input int ch, output int high, output int len,
                         output int first, output int runs);
    int w;
    bit prev;
    high  = 0;
    len   = 0;
    first = -1;
    runs  = 0;
    prev  = 1'b0;
    w     = 0;
    @(negedge clk);
    while (!bus.sync_pulse && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (!bus.sync_pulse) begin
      check("sync_wait_timeout", w, 0);
      return;
    end
    do begin
      if (bus.pwm_out[ch]) begin
        high++;
        if (first < 0) first = len;
        if (!prev) runs++;
      end
      prev = bus.pwm_out[ch];
      len++;
      @(negedge clk);
    end while (!bus.sync_pulse && len < 600);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, f, r, bad;

    vecs[0] = '{1'b0, 10, 5, 5, 10, 0, 1};
    vecs[1] = '{1'b0, 10, 2, 2, 10, 0, 1};
    vecs[2] = '{1'b0,  6, 7, 6,  6, 0, 1};
    vecs[3] = '{1'b0,  6, 0, 0,  6, -1, 0};
    vecs[4] = '{1'b1,  8, 3, 6, 16, 5, 1};
    vecs[5] = '{1'b1,  5, 1, 2, 10, 4, 1};

    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.btn_inc     = 1'b0;
    bus.btn_dec     = 1'b0;
    bus.ch_sel      = '0;
    bus.mode_center = 1'b0;
    bus.period      = 8'd10;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst pwm_out", int'(bus.pwm_out), 0);
    check("rst sync_pulse", int'(bus.sync_pulse), 0);
    for (int c = 0; c < 4; c++) begin
      bus.ch_sel = 2'(c);
      #1;
      check($sformatf("rst duty_rd ch%0d", c), int'(bus.duty_rd), 0);
    end
    rst = 1'b0;

    // Duty stays writable while disabled; outputs stay quiet.
    set_duty(0, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pwm_out != 0 || bus.sync_pulse) bad++;
    end
    check("en=0 outputs quiet", bad, 0);
    bus.en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      bus.mode_center = vecs[v].mode;
      bus.period      = 8'(vecs[v].period);
      set_duty(0, vecs[v].duty);
      measure(0, h, l, f, r);
      check($sformatf("vec%0d high", v), h, vecs[v].exp_high);
      check($sformatf("vec%0d len", v), l, vecs[v].exp_len);
      check($sformatf("vec%0d first", v), f, vecs[v].exp_first);
      check($sformatf("vec%0d runs", v), r, vecs[v].exp_runs);
    end

    // Bouncing button yields a single step.
    bus.mode_center = 1'b0;
    bus.period      = 8'd10;
    bus.ch_sel      = 2'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      bus.btn_inc = ~bus.btn_inc;
      @(posedge clk);
      #1;
    end
    bus.btn_inc = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    bus.btn_inc = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("bounce duty_rd ch2", int'(bus.duty_rd), 1);

    // Saturation at both ends on channel 1.
    bus.ch_sel = 2'd1;
    repeat (3) press(1'b0, 1'b1);
    check("dec floor duty_rd", int'(bus.duty_rd), 0);
    measure(1, h, l, f, r);
    check("dec floor pwm high", h, 0);
    set_duty(1, 255);
    press(1'b1, 1'b0);
    check("inc ceiling duty_rd", int'(bus.duty_rd), 255);
    measure(1, h, l, f, r);
    check("inc ceiling pwm high", h, 10);
    check("inc ceiling len", l, 10);

    // Mid-period duty change only takes effect at the next boundary.
    bus.period = 8'd250;
    set_duty(0, 2);
    fork
      measure(0, h, l, f, r);
      begin
        int w = 0;
        @(negedge clk);
        while (!bus.sync_pulse && w < 600) begin
          @(negedge clk);
          w++;
        end
        repeat (5) press(1'b1, 1'b0);
      end
    join
    check("midchg old high", h, 2);
    check("midchg old len", l, 250);
    check("midchg duty_rd", int'(bus.duty_rd), 7);
    measure(0, h, l, f, r);
    check("midchg new high", h, 7);
    check("midchg new len", l, 250);

    // Simultaneous inc and dec cancel.
    set_duty(3, 4);
    press(1'b1, 1'b1);
    check("inc+dec duty_rd ch3", int'(bus.duty_rd), 4);

    // Reset in the middle of a period.
    bus.ch_sel = 2'd0;
    measure(0, h, l, f, r);
    repeat (3) @(posedge clk);
    #1;
    check("pre-rst pwm_out[0]", int'(bus.pwm_out[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid rst pwm_out", int'(bus.pwm_out), 0);
    check("mid rst sync_pulse", int'(bus.sync_pulse), 0);
    check("mid rst duty_rd ch0", int'(bus.duty_rd), 0);
    bus.ch_sel = 2'd3;
    #1;
    check("mid rst duty_rd ch3", int'(bus.duty_rd), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post rst sync_pulse", int'(bus.sync_pulse), 1);
    check("post rst pwm_out", int'(bus.pwm_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
